// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM state encoding,
// baud divisor calculation and line-level constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Rounded clock-cycles-per-bit, so odd ratios land on the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// DEPTH must be a power of two; pointers wrap naturally.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter (8 data bits, no parity, 1 or 2 stop bits).
// Define UART_TX_FIFO_EN to place a FifoDepth-entry FIFO ahead of the shifter.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 9600,
    parameter int StopBits     = 1,
    parameter int FifoDepth    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 TxD_start,
    input  logic [DATA_BITS-1:0] TxD_data,
    output logic                 TxD_busy,
    output logic                 TxD,
    output logic                 tx_idle
);

    localparam int DIV   = calc_div(ClkFrequency, Baud);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("StopBits must be 1 or 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("FifoDepth must be a power of two and at least 2");
    end

    tx_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;

    logic                 accept;
    logic                 bit_end;
    logic                 stop_last;
    logic                 frame_end;
    logic                 byte_avail;
    logic                 load;
    logic [DATA_BITS-1:0] next_byte;

    assign accept    = TxD_start && !TxD_busy;
    assign bit_end   = (cnt == CNT_LAST);
    assign stop_last = (StopBits == 2) ? stop_idx : 1'b1;
    assign frame_end = (state == STOP) && bit_end && stop_last;
    // Loading straight out of STOP gives back-to-back frames with no idle gap.
    assign load      = byte_avail && ((state == IDLE) || frame_end);

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ack_q;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (TxD_data),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One-cycle ack pulse makes the wrapper drop its level request after each push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= accept;
    end

    assign TxD_busy   = fifo_full || ack_q;
    assign byte_avail = !fifo_empty;
    assign next_byte  = fifo_rdata;
    assign tx_idle    = (state == IDLE) && fifo_empty;
`else
    logic busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         busy_q <= 1'b0;
        else if (accept)    busy_q <= 1'b1;
        else if (frame_end) busy_q <= 1'b0;
    end

    assign TxD_busy   = busy_q;
    assign byte_avail = accept;
    assign next_byte  = TxD_data;
    assign tx_idle    = (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            TxD      <= STOP_LVL;
        end else if (load) begin
            state <= START;
            cnt   <= '0;
            shreg <= next_byte;
            TxD   <= START_LVL;
        end else begin
            case (state)
                IDLE: ;
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        TxD     <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            TxD      <= STOP_LVL;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TxD     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_last) state    <= IDLE;
                        else           stop_idx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer at DIV=16 (1600 Hz clock, 100 baud).
// Build with UART_TX_FIFO_EN defined to exercise the FIFO variant.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int DIV = 16;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data = 8'h00;
    logic       TxD_busy, TxD, tx_idle;
    logic       start2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       busy2, txd2, idle2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_data[$];
    bit         got_bad[$];
    int         got_start[$];
    int         got_end[$];

    uart_tx_serializer #(.ClkFrequency(1600), .Baud(100), .StopBits(1), .FifoDepth(4)) dut (
        .clk(clk), .rst_n(rst_n), .TxD_start(TxD_start), .TxD_data(TxD_data),
        .TxD_busy(TxD_busy), .TxD(TxD), .tx_idle(tx_idle));

    uart_tx_serializer #(.ClkFrequency(1600), .Baud(100), .StopBits(2), .FifoDepth(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .TxD_start(start2), .TxD_data(data2),
        .TxD_busy(busy2), .TxD(txd2), .tx_idle(idle2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Line decoder: frames are aligned to the first low sample, each bit must be
    // constant for DIV samples, data is taken mid-bit.
    bit         d_active = 1'b0;
    int         d_pos, d_st, d_bi, d_off;
    logic       d_first;
    logic [7:0] d_sh;
    bit         d_bad;
    always @(negedge clk) begin
        if (!rst_n) begin
            d_active = 1'b0;
        end else begin
            if (!d_active && TxD == 1'b0) begin
                d_active = 1'b1; d_pos = 0; d_bad = 1'b0; d_st = cyc;
            end
            if (d_active) begin
                d_bi = d_pos / DIV; d_off = d_pos % DIV;
                if (d_off == 0) d_first = TxD;
                else if (TxD !== d_first) d_bad = 1'b1;
                if (d_off == DIV / 2) begin
                    if (d_bi >= 1 && d_bi <= 8) d_sh[d_bi-1] = TxD;
                    else if (d_bi == 0 && TxD !== 1'b0) d_bad = 1'b1;
                    else if (d_bi == 9 && TxD !== 1'b1) d_bad = 1'b1;
                end
                if (d_pos == 10 * DIV - 1) begin
                    got_data.push_back(d_sh); got_bad.push_back(d_bad);
                    got_start.push_back(d_st); got_end.push_back(cyc);
                    d_active = 1'b0;
                end else begin
                    d_pos++;
                end
            end
        end
    end

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < n * 11 * DIV + 400; t++) begin
            if (got_data.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_data.delete(); got_bad.delete(); got_start.delete(); got_end.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        bit ok;
        ok = 1'b0;
        TxD_data = b; TxD_start = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (TxD_busy) begin ok = 1'b1; break; end
        end
        acc = cyc; TxD_start = 1'b0;
        exp_q.push_back(b);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL send_ack byte=%h busy never rose", b); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; TxD_start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({TxD, TxD_busy, tx_idle} !== 3'b101) begin
            miscompares++; $display("FAIL reset_hold txd/busy/idle got=%b exp=101", {TxD, TxD_busy, tx_idle});
        end
        vectors++;
        if ({txd2, busy2, idle2} !== 3'b101) begin
            miscompares++; $display("FAIL reset_hold2 got=%b exp=101", {txd2, busy2, idle2});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({TxD, TxD_busy, tx_idle} !== 3'b101) begin
            miscompares++; $display("FAIL reset_after got=%b exp=101", {TxD, TxD_busy, tx_idle});
        end
        clear_sb();
    endtask

    task automatic test_single();
        int acc, fall, k;
        bit ok;
        TxD_data = 8'h55; TxD_start = 1'b1; exp_q.push_back(8'h55);
        @(negedge clk);
        acc = cyc;
        vectors++;
        if ({TxD, TxD_busy, tx_idle} !== 3'b010) begin
            miscompares++; $display("FAIL accept_state txd/busy/idle got=%b exp=010", {TxD, TxD_busy, tx_idle});
        end
        repeat (2) @(negedge clk);
        TxD_start = 1'b0;
        fall = -1;
        for (int t = 0; t < 400; t++) begin
            if (!TxD_busy) begin fall = cyc; break; end
            @(negedge clk);
        end
        vectors++;
        if (fall - acc !== 160) begin
            miscompares++; $display("FAIL busy_len got=%0d exp=160", fall - acc);
        end
        wait_frames(1, ok);
        repeat (40) @(negedge clk);
        vectors++;
        if (got_data.size() !== 1) begin
            miscompares++; $display("FAIL frame_count got=%0d exp=1", got_data.size());
        end
        k = got_data.size();
        if (k > 0) begin
            vectors++;
            if (got_data[0] !== exp_q[0] || got_bad[0]) begin
                miscompares++; $display("FAIL single_data got=%h bad=%0d exp=%h", got_data[0], got_bad[0], exp_q[0]);
            end
            vectors++;
            if (got_start[0] !== acc) begin
                miscompares++; $display("FAIL start_latency got=%0d exp=%0d", got_start[0], acc);
            end
        end
        vectors++;
        if (tx_idle !== 1'b1) begin miscompares++; $display("FAIL idle_after got=%b exp=1", tx_idle); end
        clear_sb();
    endtask

    task automatic test_b2b();
        int acc1, acc2;
        bit ok;
        send_byte(8'hA3, acc1);
        for (int t = 0; t < 400; t++) begin
            if (!TxD_busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        send_byte(8'h3C, acc2);
        wait_frames(2, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_frames got=%0d exp=2", got_data.size()); end
        for (int k = 0; k < 2 && k < got_data.size(); k++) begin
            vectors++;
            if (got_data[k] !== exp_q[k] || got_bad[k]) begin
                miscompares++; $display("FAIL b2b_data[%0d] got=%h bad=%0d exp=%h", k, got_data[k], got_bad[k], exp_q[k]);
            end
        end
        if (got_start.size() >= 2) begin
            vectors++;
            if (got_start[1] !== acc2) begin
                miscompares++; $display("FAIL b2b_start got=%0d exp=%0d", got_start[1], acc2);
            end
        end
        clear_sb();
    endtask

    task automatic test_reset_mid();
        int acc, acc2;
        bit ok;
        send_byte(8'hF0, acc);
`ifdef UART_TX_FIFO_EN
        @(negedge clk);
        send_byte(8'h11, acc2);
`endif
        while (cyc < acc + LAT + 70) @(negedge clk);
        vectors++;
        if (TxD !== 1'b0) begin miscompares++; $display("FAIL mid_frame_txd got=%b exp=0", TxD); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({TxD, TxD_busy, tx_idle} !== 3'b101) begin
            miscompares++; $display("FAIL reset_mid got=%b exp=101", {TxD, TxD_busy, tx_idle});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        repeat (200) @(negedge clk);
        vectors++;
        if (got_data.size() !== 0 || TxD !== 1'b1) begin
            miscompares++; $display("FAIL no_partial frames=%0d txd=%b exp=0/1", got_data.size(), TxD);
        end
        send_byte(8'h96, acc2);
        wait_frames(1, ok);
        vectors++;
        if (!ok || got_data[0] !== 8'h96 || got_bad[0]) begin
            miscompares++;
            $display("FAIL after_reset_data got=%h exp=96", ok ? got_data[0] : 8'hxx);
        end
        repeat (20) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_stop2();
        int nb, nlow, lastlow;
        data2 = 8'hFF; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        nb = 0; nlow = 0; lastlow = -1;
        for (int t = 0; t < 400; t++) begin
            if (!busy2) break;
            if (!txd2) begin nlow++; lastlow = nb; end
            nb++;
            @(negedge clk);
        end
        vectors++;
        if (nb !== 176) begin miscompares++; $display("FAIL stop2_frame_len got=%0d exp=176", nb); end
        vectors++;
        if (nlow !== 16 || lastlow !== 15) begin
            miscompares++; $display("FAIL stop2_low got=%0d/%0d exp=16/15", nlow, lastlow);
        end
        vectors++;
        if ({txd2, idle2} !== 2'b11) begin miscompares++; $display("FAIL stop2_idle got=%b exp=11", {txd2, idle2}); end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo_burst();
        logic [7:0] b[5];
        int idle_cyc;
        bit ok;
        b[0] = 8'h11; b[1] = 8'h2E; b[2] = 8'h5A; b[3] = 8'hC4; b[4] = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            TxD_data = b[i]; TxD_start = 1'b1; exp_q.push_back(b[i]);
            @(negedge clk);
            vectors++;
            if (TxD_busy !== 1'b1) begin miscompares++; $display("FAIL busy_pulse[%0d] got=%b exp=1", i, TxD_busy); end
            TxD_start = 1'b0;
            @(negedge clk);
            vectors++;
            if (TxD_busy !== (i == 4)) begin
                miscompares++; $display("FAIL busy_after[%0d] got=%b exp=%b", i, TxD_busy, i == 4);
            end
        end
        repeat (100) @(negedge clk);
        vectors++;
        if (TxD_busy !== 1'b1) begin miscompares++; $display("FAIL busy_full_hold got=%b exp=1", TxD_busy); end
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!TxD_busy) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL busy_release got=1 exp=0"); end
        idle_cyc = -1;
        for (int t = 0; t < 1200; t++) begin
            @(negedge clk);
            if (tx_idle) begin idle_cyc = cyc; break; end
        end
        wait_frames(5, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL burst_frames got=%0d exp=5", got_data.size()); end
        for (int k = 0; k < 5 && k < got_data.size(); k++) begin
            vectors++;
            if (got_data[k] !== exp_q[k] || got_bad[k]) begin
                miscompares++; $display("FAIL burst_data[%0d] got=%h bad=%0d exp=%h", k, got_data[k], got_bad[k], exp_q[k]);
            end
            if (k > 0) begin
                vectors++;
                if (got_start[k] - got_start[k-1] !== 160) begin
                    miscompares++; $display("FAIL burst_gap[%0d] got=%0d exp=160", k, got_start[k] - got_start[k-1]);
                end
            end
        end
        if (got_end.size() >= 5) begin
            vectors++;
            if (idle_cyc !== got_end[4] + 1) begin
                miscompares++; $display("FAIL idle_rise got=%0d exp=%0d", idle_cyc, got_end[4] + 1);
            end
        end
        clear_sb();
    endtask

    task automatic test_fifo_simul();
        int acc, acc2, s_a;
        bit ok;
        send_byte(8'h3A, acc);
        s_a = acc + 1;
        @(negedge clk);
        send_byte(8'hB5, acc2);
        while (cyc < s_a + 159) @(negedge clk);
        vectors++;
        if (TxD_busy !== 1'b0) begin miscompares++; $display("FAIL simul_ready got=%b exp=0", TxD_busy); end
        TxD_data = 8'h6C; TxD_start = 1'b1; exp_q.push_back(8'h6C);
        @(negedge clk);
        TxD_start = 1'b0;
        vectors++;
        if (TxD_busy !== 1'b1) begin miscompares++; $display("FAIL simul_ack got=%b exp=1", TxD_busy); end
        wait_frames(3, ok);
        repeat (20) @(negedge clk);
        vectors++;
        if (got_data.size() !== 3) begin miscompares++; $display("FAIL simul_frames got=%0d exp=3", got_data.size()); end
        for (int k = 0; k < 3 && k < got_data.size(); k++) begin
            vectors++;
            if (got_data[k] !== exp_q[k] || got_bad[k] || got_start[k] !== s_a + 160 * k) begin
                miscompares++;
                $display("FAIL simul_data[%0d] got=%h@%0d exp=%h@%0d", k, got_data[k], got_start[k], exp_q[k], s_a + 160 * k);
            end
        end
        vectors++;
        if (tx_idle !== 1'b1) begin miscompares++; $display("FAIL simul_idle got=%b exp=1", tx_idle); end
        clear_sb();
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_TX_FIFO_EN
        test_reset_mid();
        test_fifo_burst();
        test_fifo_simul();
`else
        test_single();
        test_b2b();
        test_reset_mid();
        test_stop2();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
